tc_clk_div_multi: RTL and testbench
===================================

// Module: tc_clk_div_multi
// PURPOSE
//   Parametrised N-channel integer clock divider with per-channel run control and glitch-free ratio update.
//   Generalises the tc_clk_* cells from single-purpose gating/muxing to runtime-programmable divided clocks.
//   Sits at SoC/FPGA clock roots and feeds peripheral domains (SPI, UART, timers) from one source clock.
//   Every divided clock is the output of a flop; test mode bypasses all channels to clk_i.
// PARAMETERS
//   NUM_CH       4    number of independent divider channels (>=1)
//   CNT_W        8    divider ratio width; legal ratio 2..2**CNT_W-1
//   DEFAULT_DIV  2    ratio loaded into every channel at reset (2..2**CNT_W-1)
// PORTS
//   clk_i          in   1             source clock; single clock domain for all control logic
//   rst_i          in   1             reset, asynchronous assert, active-high
//   test_mode_i    in   1             static DFT bypass: clk_o[c] = clk_i for all c
//   en_i           in   NUM_CH        per-channel run request, synchronous to clk_i
//   div_i          in   NUM_CH*CNT_W  requested ratio, channel c at [c*CNT_W +: CNT_W]
//   div_valid_i    in   NUM_CH        per-channel ratio update request
//   div_ready_o    out  NUM_CH        per-channel ratio update accept
//   running_o      out  NUM_CH        channel currently toggling
//   clk_o          out  NUM_CH        divided clocks
// BEHAVIOUR
//   - Reset, all channels: div_q=DEFAULT_DIV, cnt_q=0, clk_q=0, running_o=0, pending=0, div_ready_o=1.
//   - Ratio clamp: div_i values 0 and 1 are stored as 2. No other value is modified.
//   - Counter: when running, cnt_q steps 0..div_q-1 and wraps to 0. The cycle where cnt_q==div_q-1 is the period boundary.
//   - Output: clk_q is registered and clk_q==1 iff running && cnt_q < ceil(div_q/2).
//     Even N gives exactly 50% duty. Odd N is high for (N+1)/2 cycles and low for (N-1)/2.
//     Every rising edge of clk_o coincides with cnt_q==0.
//   - Per-channel states:
//     STOPPED: cnt_q=0, clk_q=0. If en_i=1, go to RUNNING next cycle, and clk_o rises on that edge.
//     RUNNING: at the period boundary, if en_i=0, go to STOPPED.
//       The channel never stops mid-period; clk_o always ends low and no runt pulse is produced.
//   - running_o=1 in RUNNING, 0 in STOPPED.
//   - Ratio handshake:
//     div_ready_o = ~pending. The transfer happens when div_valid_i & div_ready_o; the clamped value goes to div_pend_q and pending is set.
//     Apply in RUNNING: div_q<=div_pend_q and pending<=0 at the period boundary. The new ratio governs the next period.
//     Apply in STOPPED: div_q<=div_pend_q and pending<=0 on the cycle after the transfer.
//     While pending=1, div_valid_i is ignored and div_i must be held by the requester (valid/ready rules).
//   - Simultaneous events at the period boundary, same cycle: a ratio apply and an en_i=0 stop both take effect.
//     A transfer and a boundary in the same cycle: the new value waits for the following boundary. It is not applied that cycle.
//   - Test mode: test_mode_i=1 selects clk_i on every clk_o through tc_clk_mux2.
//     Counters, state and handshake keep running unchanged. test_mode_i must be static during functional operation.
//   - Reset mid-operation: clk_o drops to 0 asynchronously and pending updates are discarded.
//   - Channels are fully independent; no cross-channel phase alignment is guaranteed.
// STRUCTURE
//   - Package tc_clk_div_pkg: typedef logic [CNT_W-1:0] div_t (parametrised via localparam in user),
//     typedef enum logic {STOPPED, RUNNING} ch_state_e, function clamp_div().
//   - Sub-module tc_clk_div_ch: one channel containing the counter, FSM, handshake and clk_q.
//     Instantiated NUM_CH times in a generate loop.
//   - Per channel, one tc_clk_mux2 instance (clk0_i=clk_q, clk1_i=clk_i, clk_sel_i=test_mode_i) drives clk_o[c].
//   - No combinational path from any data input to clk_o except through test_mode_i.
// TESTING
//   1. Reset, en_i=1 on ch0 with default 2 -> clk_o[0] toggles every clk_i cycle (period 2, 50%), running_o[0]=1 one cycle after en_i.
//   2. Ch1 div_i=5 accepted while stopped, then en_i=1 -> clk_o[1] high 3 cycles, low 2, repeating; div_ready_o[1] high again 1 cycle after transfer.
//   3. Ch2 running at 4, write 6 at cnt_q=1 -> remaining period still 4 cycles, next period 6 (3 high/3 low);
//      div_ready_o[2]=0 until that boundary, and a second valid during this time is ignored.
//   4. Ch3 running at 7, drop en_i at cnt_q=2 -> output completes the period (high 4, low 3), then stays low; running_o[3]=0 after the boundary.
//   5. div_i=0 and div_i=1 -> both behave as divide-by-2.
//      div_i=255 with CNT_W=8 -> high 128 / low 127.
//   6. test_mode_i=1 -> all clk_o follow clk_i. rst_i asserted mid-period -> clk_o=0 and div_ready_o=1 immediately;
//      after release, ratio=DEFAULT_DIV.

Source files
------------

// File: rtl/tc_clk_div_pkg.sv
// Shared types and helpers for the multi-channel integer clock divider.
package tc_clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic {STOPPED, RUNNING} ch_state_e;

    // Ratios below 2 cannot produce a toggling clock, so they are raised to 2.
    function automatic int unsigned clamp_div(input int unsigned div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/tc_clk_div_ch.sv
// One divider channel: period counter, run/stop FSM, ratio handshake and registered clock.
module tc_clk_div_ch
    import tc_clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic             running_o,
    output logic             clk_o
);

    typedef logic [CNT_W-1:0] div_t;

    ch_state_e    state_q, state_d;
    div_t         cnt_q, cnt_d;
    div_t         div_q, div_d;
    div_t         pend_val_q, pend_val_d;
    logic         pend_q, pend_d;
    logic         clk_q, clk_d;
    logic         boundary;
    logic         xfer;
    logic [CNT_W:0] high_cycles;

    assign boundary = (state_q == RUNNING) && (cnt_q == div_q - div_t'(1));
    assign xfer     = div_valid_i && !pend_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= STOPPED;
            cnt_q      <= '0;
            div_q      <= div_t'(DEFAULT_DIV);
            pend_val_q <= div_t'(DEFAULT_DIV);
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
        end
    end

    // Stopping is only allowed at the period boundary so no runt pulse leaves the channel.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: if (en_i) state_d = RUNNING;
            RUNNING: if (boundary && !en_i) state_d = STOPPED;
            default: state_d = STOPPED;
        endcase
    end

    always_comb begin
        div_d      = div_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        cnt_d      = '0;
        // A pending ratio lands between periods: at once when stopped, else at the boundary.
        if (pend_q && ((state_q == STOPPED) || boundary)) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
        end
        if (xfer) begin
            pend_d     = 1'b1;
            pend_val_d = div_t'(clamp_div(32'(div_i)));
        end
        if ((state_q == RUNNING) && !boundary) begin
            cnt_d = cnt_q + div_t'(1);
        end
    end

    // Registered output is computed from next-state so clk_q matches cnt_q/div_q after the edge.
    always_comb begin
        high_cycles = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
        clk_d       = (state_d == RUNNING) && ({1'b0, cnt_d} < high_cycles);
    end

    assign div_ready_o = !pend_q;
    assign running_o   = (state_q == RUNNING);
    assign clk_o       = clk_q;

endmodule

// File: rtl/tc_clk_mux2.sv
// Two-input clock multiplexer cell; clk_sel_i=1 selects clk1_i.
module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/tc_clk_div_multi.sv
// N-channel runtime-programmable integer clock divider with DFT bypass to the source clock.
module tc_clk_div_multi
    import tc_clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    test_mode_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_valid_i,
    output logic [NUM_CH-1:0]       div_ready_o,
    output logic [NUM_CH-1:0]       running_o,
    output logic [NUM_CH-1:0]       clk_o
);

    logic [NUM_CH-1:0] clk_div;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tc_clk_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .en_i        (en_i[c]),
            .div_i       (div_i[c*CNT_W +: CNT_W]),
            .div_valid_i (div_valid_i[c]),
            .div_ready_o (div_ready_o[c]),
            .running_o   (running_o[c]),
            .clk_o       (clk_div[c])
        );

        tc_clk_mux2 u_mux (
            .clk0_i    (clk_div[c]),
            .clk1_i    (clk_i),
            .clk_sel_i (test_mode_i),
            .clk_o     (clk_o[c])
        );
    end

endmodule

// File: tb/tb_tc_clk_div_multi.sv
// Scoreboard bench: a waveform-queue reference model predicts every channel each cycle.
module tb_tc_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int DEF    = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    test_mode = 1'b0;
    logic [NUM_CH-1:0]       en = '0;
    logic [NUM_CH-1:0]       valid = '0;
    logic [NUM_CH*CNT_W-1:0] div_in = '0;
    logic [NUM_CH-1:0]       ready;
    logic [NUM_CH-1:0]       running;
    logic [NUM_CH-1:0]       clk_out;

    tc_clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .test_mode_i (test_mode),
        .en_i        (en),
        .div_i       (div_in),
        .div_valid_i (valid),
        .div_ready_o (ready),
        .running_o   (running),
        .clk_o       (clk_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] run;
        logic [NUM_CH-1:0] rdy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: each running channel holds the rest of its current period as a bit queue.
    bit          m_run  [NUM_CH];
    bit          m_pend [NUM_CH];
    int unsigned m_div  [NUM_CH];
    int unsigned m_pval [NUM_CH];
    bit          m_wave [NUM_CH][$];

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_run[c]  = 1'b0;
            m_pend[c] = 1'b0;
            m_div[c]  = DEF;
            m_pval[c] = DEF;
            m_wave[c].delete();
        end
    endtask

    task automatic model_edge();
        exp_t        e;
        bit          old_pend;
        int unsigned d;
        for (int c = 0; c < NUM_CH; c++) begin
            old_pend = m_pend[c];
            d = int'(div_in[c*CNT_W +: CNT_W]);
            if (!m_run[c] || m_wave[c].size() == 0) begin
                if (old_pend) begin
                    m_div[c]  = m_pval[c];
                    m_pend[c] = 1'b0;
                end
                m_run[c] = en[c];
                if (en[c]) begin
                    for (int unsigned i = 0; i < m_div[c]; i++)
                        m_wave[c].push_back(i < (m_div[c] + 1) / 2);
                end
            end
            if (valid[c] && !old_pend) begin
                m_pend[c] = 1'b1;
                m_pval[c] = (d < 2) ? 2 : d;
            end
            e.clk[c] = m_run[c] ? m_wave[c].pop_front() : 1'b0;
            e.run[c] = m_run[c];
            e.rdy[c] = !m_pend[c];
        end
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            if (test_mode) check("test_mode_clk_high", int'(clk_out), (1 << NUM_CH) - 1);
        end
    endtask

    task automatic set_div(input int c, input int v);
        div_in[c*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("clk_o", int'(clk_out), test_mode ? 0 : int'(e.clk));
                check("running_o", int'(running), int'(e.run));
                check("div_ready_o", int'(ready), int'(e.rdy));
            end
        end
    end

    initial begin
        model_reset();
        #1;
        check("reset_clk_o", int'(clk_out), 0);
        check("reset_running_o", int'(running), 0);
        check("reset_div_ready_o", int'(ready), (1 << NUM_CH) - 1);
        #11 rst = 1'b0;

        // Channel 0 at the default ratio.
        en[0] = 1'b1;
        step(10);

        // Channel 1: ratio 5 loaded while stopped, then started.
        set_div(1, 5); valid[1] = 1'b1; step(1);
        valid[1] = 1'b0; step(2);
        en[1] = 1'b1; step(15);

        // Channel 2: running at 4, update to 6 mid-period; a second request while pending is ignored.
        set_div(2, 4); valid[2] = 1'b1; step(1);
        valid[2] = 1'b0; step(1);
        en[2] = 1'b1; step(2);
        set_div(2, 6); valid[2] = 1'b1; step(1);
        set_div(2, 9); step(2);
        valid[2] = 1'b0; step(14);

        // Channel 3: running at 7, enable dropped mid-period.
        set_div(3, 7); valid[3] = 1'b1; step(1);
        valid[3] = 1'b0; en[3] = 1'b1; step(3);
        en[3] = 1'b0; step(12);

        // Clamped ratios 0 and 1, then the widest ratio.
        set_div(0, 0); valid[0] = 1'b1; step(1);
        valid[0] = 1'b0; set_div(1, 1); valid[1] = 1'b1; step(1);
        valid[1] = 1'b0; step(12);
        set_div(0, 255); valid[0] = 1'b1; step(1);
        valid[0] = 1'b0; step(520);

        // Test-mode bypass; internal state keeps advancing.
        test_mode = 1'b1; step(8);
        test_mode = 1'b0; step(2);

        // Randomised traffic on all channels.
        repeat (400) begin
            for (int c = 0; c < NUM_CH; c++) begin
                en[c]    = ($urandom_range(0, 7) != 0);
                valid[c] = ($urandom_range(0, 3) == 0);
                set_div(c, $urandom_range(0, 12));
            end
            step(1);
        end

        // Asynchronous reset mid-period.
        valid = '0; set_div(0, 9); valid[0] = 1'b1; en = '1; step(3);
        valid = '0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_clk_o", int'(clk_out), 0);
        check("async_rst_running_o", int'(running), 0);
        check("async_rst_div_ready_o", int'(ready), (1 << NUM_CH) - 1);
        sb.delete();
        en = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        en[0] = 1'b1; step(8);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
